// File: rtl/axis_fork_lane_sink.sv
// -----------------------------------------------------------------------------
// axis_fork_lane_sink
//
// Per-lane receive stage that sits directly downstream of one output lane of
// the fork arbiter. It consumes the lane's AXI-Stream and strips the
// end-of-fork marker beat (tdata all ones with tlast=1). The last real data
// word of the frame is re-marked with tlast. Words are buffered in a FIFO,
// and frame completion is reported to the lane controller.
//
// A one-word hold register sits in front of the FIFO. A word is only known to
// be "last" once the following beat arrives, so every DATA word waits in the
// hold register until the next beat is accepted.
//
// Optional build macro: AXIS_LANE_STAT_EN
//   defined   : frame_words captures word_count on each completed frame, and
//               a 32-bit frame counter (r_frame_cnt) counts completed frames.
//   undefined : frame_words is tied to zero and no statistics flops exist.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_*            lane input stream (tready combinational, no tvalid path)
//   m_axis_*            buffered output stream (head of FIFO)
//   lane_done           one-cycle pulse once a frame has fully drained
//   word_count          data words pushed in the current frame (saturating)
//   err_tlast           sticky: tlast seen on a non-marker beat
//   frame_words         word count of the last completed frame (statistics)
// -----------------------------------------------------------------------------
module axis_fork_lane_sink #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   output logic                  lane_done,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  err_tlast,
   output logic [31:0]           frame_words
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [DATA_WIDTH-1:0] r_hold_data;
   logic                  r_hold_valid;

   logic [DATA_WIDTH:0]   r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         w_rd_ptr_next;

   logic [CNT_WIDTH-1:0]  r_word_count;
   logic                  r_err_tlast;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_marker;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_drained;
   logic [DATA_WIDTH:0]   w_head;

   // ---------------------------------------------------------------------------
   // Beat classification and handshakes
   // ---------------------------------------------------------------------------
   assign w_marker = s_axis_tlast & (&s_axis_tdata);

   // Held low during reset. Otherwise it depends only on state and FIFO room.
   assign s_axis_tready = rst_n & ((r_state == S_RUN) | (r_state == S_IDLE)) & ~w_full;

   assign w_accept = s_axis_tvalid & s_axis_tready;

   // Any accepted beat flushes a waiting word. Only a marker tags it as last.
   assign w_push   = w_accept & r_hold_valid;
   assign w_pop    = ~w_empty & m_axis_tready;

   // ---------------------------------------------------------------------------
   // FIFO: wrap-bit pointers, full/empty from MSB comparison
   // ---------------------------------------------------------------------------
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
   // No pushes happen in DRAIN, so "empty after this cycle's pop" only needs the
   // advanced read pointer.
   assign w_drained     = (w_rd_ptr_next == r_wr_ptr);

   // Storage array carries no reset. Its contents are unobservable while the
   // pointers say empty, and the outputs are gated to zero in that case.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {w_marker, r_hold_data};
      end
   end

   assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
   assign m_axis_tvalid = ~w_empty;
   assign m_axis_tdata  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
   assign m_axis_tlast  = ~w_empty & w_head[DATA_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         r_rd_ptr <= w_rd_ptr_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Hold register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_data  <= '0;
         r_hold_valid <= 1'b0;
      end else if (w_accept) begin
         if (w_marker) begin
            r_hold_valid <= 1'b0;
         end else begin
            r_hold_data  <= s_axis_tdata;
            r_hold_valid <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = w_marker ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (w_accept && w_marker) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_drained) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign lane_done = (r_state == S_DONE);

   // ---------------------------------------------------------------------------
   // Counters and error flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_count <= '0;
         r_err_tlast  <= 1'b0;
      end else begin
         // DONE always exits to IDLE, so clearing here equals "entering IDLE".
         if (r_state == S_DONE) begin
            r_word_count <= '0;
         end else if (w_push && !(&r_word_count)) begin
            r_word_count <= r_word_count + CNT_WIDTH'(1);
         end
         if (w_accept && s_axis_tlast && !w_marker) begin
            r_err_tlast <= 1'b1;
         end
      end
   end

   assign word_count = r_word_count;
   assign err_tlast  = r_err_tlast;

`ifdef AXIS_LANE_STAT_EN
   logic [31:0] r_frame_words;
   logic [31:0] r_frame_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_words <= '0;
         r_frame_cnt   <= '0;
      end else if (r_state == S_DONE) begin
         r_frame_words <= 32'(r_word_count);
         r_frame_cnt   <= r_frame_cnt + 32'd1;
      end
   end

   assign frame_words = r_frame_words;
`else
   assign frame_words = '0;
`endif

endmodule

// File: tb/tb_axis_fork_lane_sink.sv
module tb_axis_fork_lane_sink;

   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tlast;
   logic          s_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          lane_done;
   logic [CW-1:0] word_count;
   logic          err_tlast;
   logic [31:0]   frame_words;

   always #5 clk = ~clk;

   axis_fork_lane_sink #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .lane_done     (lane_done),
      .word_count    (word_count),
      .err_tlast     (err_tlast),
      .frame_words   (frame_words)
   );

   // Reference model: every accepted input beat in arrival order. An output
   // word must be the oldest DATA beat, and it is "last" exactly when the next
   // accepted beat is a marker.
   typedef struct packed {
      logic          mk;
      logic [DW-1:0] d;
   } beat_t;

   beat_t         exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            tick_n = 0;
   int            done_cnt = 0;
   int            done_tick = -1;
   int            last_pop_tick = -1;
   int            pop_cnt = 0;
   int            acc_cnt = 0;
   logic [CW-1:0] done_wc = '0;
   bit            rand_ready = 1'b0;
   bit            last_acc = 1'b0;
   logic [DW-1:0] all_ones = '1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle. Entered just after a falling edge with inputs applied.
   task automatic tick();
      beat_t b;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      #1;
      last_acc = s_axis_tvalid && s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
         while (exp_q.size() > 0 && exp_q[0].mk) void'(exp_q.pop_front());
         if (exp_q.size() < 2) begin
            chk("pop_unexpected", 64'(exp_q.size()), 64'd2);
         end else begin
            chk("m_tdata", m_axis_tdata, exp_q[0].d);
            chk("m_tlast", 64'(m_axis_tlast), 64'(exp_q[1].mk));
            void'(exp_q.pop_front());
         end
         pop_cnt++;
         last_pop_tick = tick_n;
      end
      if (last_acc) begin
         b.mk = s_axis_tlast && (s_axis_tdata == all_ones);
         b.d  = s_axis_tdata;
         exp_q.push_back(b);
         acc_cnt++;
      end
      if (lane_done) begin
         done_cnt++;
         done_tick = tick_n;
         done_wc   = word_count;
      end
      tick_n++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int n;
      n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 2000);
      if (!last_acc) chk("send_timeout", 64'(last_acc), 64'd1);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      s_axis_tvalid = 1'b0;
      while (done_cnt < target && n < 2000) begin
         tick();
         n++;
      end
      chk("done_seen", 64'(done_cnt), 64'(target));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int p0;
      int a0;
      int k;
      int len;
      logic [31:0] exp_fw;

      rst_n         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_m_tdata", m_axis_tdata, 64'd0);
      chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_lane_done", 64'(lane_done), 64'd0);
      chk("rst_word_count", 64'(word_count), 64'd0);
      chk("rst_err_tlast", 64'(err_tlast), 64'd0);
      chk("rst_frame_words", 64'(frame_words), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("idle_s_tready", 64'(s_axis_tready), 64'd1);

      // 1: three-word frame, consumer always ready
      m_axis_tready = 1'b1;
      d0 = done_cnt;
      p0 = pop_cnt;
      send_beat(64'h1, 1'b0);
      chk("no_bypass_tvalid", 64'(m_axis_tvalid), 64'd0);
      send_beat(64'h2, 1'b0);
      send_beat(64'h3, 1'b0);
      send_beat(all_ones, 1'b1);
      wait_done(d0 + 1);
      chk("t1_done_after_pop", 64'(done_tick), 64'(last_pop_tick + 1));
      chk("t1_word_count", 64'(done_wc), 64'd3);
`ifdef AXIS_LANE_STAT_EN
      exp_fw = 32'd3;
`else
      exp_fw = 32'd0;
`endif
      chk("t1_frame_words", 64'(frame_words), 64'(exp_fw));
      idle(2);
      chk("t1_single_pulse", 64'(done_cnt), 64'(d0 + 1));
      chk("t1_wc_cleared", 64'(word_count), 64'd0);
      chk("t1_pops", 64'(pop_cnt - p0), 64'd3);

      // 2: marker-only frame from IDLE
      d0 = done_cnt;
      p0 = pop_cnt;
      send_beat(all_ones, 1'b1);
      wait_done(d0 + 1);
      chk("t2_word_count", 64'(done_wc), 64'd0);
      idle(2);
      chk("t2_no_pops", 64'(pop_cnt - p0), 64'd0);
      chk("t2_single_pulse", 64'(done_cnt), 64'(d0 + 1));

      // 3: fill with consumer stalled, then drain
      m_axis_tready = 1'b0;
      a0 = acc_cnt;
      p0 = pop_cnt;
      d0 = done_cnt;
      k  = 0;
      for (int i = 0; i < 25; i++) begin
         s_axis_tvalid = (k < 20);
         s_axis_tdata  = 64'(100 + k);
         s_axis_tlast  = 1'b0;
         tick();
         if (last_acc) k++;
      end
      s_axis_tvalid = 1'b0;
      #1;
      chk("fill_accepted", 64'(acc_cnt - a0), 64'd17);
      chk("fill_s_tready", 64'(s_axis_tready), 64'd0);
      chk("fill_m_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("fill_word_count", 64'(word_count), 64'd16);
      chk("fill_head", m_axis_tdata, 64'd100);
      m_axis_tready = 1'b1;
      send_beat(all_ones, 1'b1);
      wait_done(d0 + 1);
      chk("fill_pops", 64'(pop_cnt - p0), 64'd17);
      chk("fill_done_wc", 64'(done_wc), 64'd17);

      // 4a: push and pop together around full, across pointer wrap
      m_axis_tready = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 17; i++) send_beat(64'(500 + i), 1'b0);
      m_axis_tready = 1'b1;
      for (int i = 17; i < 60; i++) send_beat(64'(500 + i), 1'b0);
      send_beat(all_ones, 1'b1);
      wait_done(d0 + 1);
      chk("wrap_done_wc", 64'(done_wc), 64'd60);

      // 4b: random frames, random gaps, random consumer stalls
      rand_ready = 1'b1;
      for (int f = 0; f < 8; f++) begin
         d0  = done_cnt;
         len = $urandom_range(0, 40);
         for (int w = 0; w < len; w++) begin
            idle($urandom_range(0, 2));
            send_beat({$urandom, $urandom}, 1'b0);
         end
         send_beat(all_ones, 1'b1);
         wait_done(d0 + 1);
         chk("rand_done_wc", 64'(done_wc), 64'(len));
      end
      rand_ready    = 1'b0;
      m_axis_tready = 1'b1;
      idle(2);
      chk("rand_model_empty", 64'(exp_q.size() <= 1), 64'd1);

      // 5: tlast on non-marker data is stored as data and flags an error
      chk("err_before", 64'(err_tlast), 64'd0);
      d0 = done_cnt;
      send_beat(64'h5, 1'b1);
      chk("err_set", 64'(err_tlast), 64'd1);
      send_beat(64'h6, 1'b0);
      send_beat(all_ones, 1'b1);
      wait_done(d0 + 1);
      chk("err_done_wc", 64'(done_wc), 64'd2);
      idle(3);
      chk("err_sticky", 64'(err_tlast), 64'd1);

      // 6: reset mid-frame, then a clean two-word frame
      m_axis_tready = 1'b0;
      for (int i = 0; i < 5; i++) send_beat(64'(900 + i), 1'b0);
      chk("mid_word_count", 64'(word_count), 64'd4);
      rst_n = 1'b0;
      #1;
      chk("mrst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("mrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("mrst_m_tdata", m_axis_tdata, 64'd0);
      chk("mrst_word_count", 64'(word_count), 64'd0);
      chk("mrst_err_tlast", 64'(err_tlast), 64'd0);
      chk("mrst_lane_done", 64'(lane_done), 64'd0);
      exp_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_axis_tready = 1'b1;
      send_beat(64'hAA, 1'b0);
      send_beat(64'hBB, 1'b0);
      send_beat(all_ones, 1'b1);
      wait_done(d0 + 1);
      chk("post_rst_wc", 64'(done_wc), 64'd2);
`ifdef AXIS_LANE_STAT_EN
      exp_fw = 32'd2;
`else
      exp_fw = 32'd0;
`endif
      chk("post_rst_frame_words", 64'(frame_words), 64'(exp_fw));
      idle(2);
      chk("post_rst_pulses", 64'(done_cnt), 64'(d0 + 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
